// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  localparam int MUL_CYCLES_DEF = 32;
  localparam int DIV_CYCLES_DEF = 32;
  localparam int CNT_W_DEF      = 6;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_cnt.sv
// Loadable down-counter for the MDU iteration count; holds at zero instead of wrapping.
module mdu_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mdu_ctrl.sv
// Sequencer for the shared iterative MDU: runs a fixed iteration count, commits HI/LO,
// and raises the decode stall for instructions that depend on the MDU.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | MDU free; accepts startE (divide-by-zero is rejected here)
//  RUN     | md_step asserted; counter walks N-1 .. 0
//  FIN     | hilo_we asserted for one cycle, then back to IDLE
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       startE,
  input  logic [1:0] opE,
  input  logic       divzeroE,
  input  logic       hiloD,
  input  logic       muldivD,
  output logic       md_load,
  output logic       md_step,
  output logic       md_div,
  output logic       md_signed,
  output logic       hilo_we,
  output logic       md_busy,
  output logic       mdstallD,
  output logic       div0,
  output logic       proto_err
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state, state_nx;
  logic             accept;
  logic             div0_raw;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_val;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    div0_raw = 1'b0;
    md_step  = 1'b0;
    hilo_we  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (startE) begin
          if (op_is_div(opE) && divzeroE) begin
            div0_raw = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        md_step = 1'b1;
        if (cnt_zero) state_nx = ST_FIN;
      end
      ST_FIN: begin
        hilo_we  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign load_val = op_is_div(opE) ? DIV_LOAD : MUL_LOAD;

  mdu_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept),
    .load_val (load_val),
    .dec      (md_step),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Op class and signedness are held for the whole operation, not just the load cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      md_div    <= 1'b0;
      md_signed <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        md_div    <= op_is_div(opE);
        md_signed <= op_is_signed(opE);
      end
      if (startE && (state != ST_IDLE)) proto_err <= 1'b1;
    end
  end

  // Input-driven outputs are gated so nothing leaks out while reset is held.
  assign md_load  = resetn & accept;
  assign div0     = resetn & div0_raw;
  assign md_busy  = (state != ST_IDLE);
  assign mdstallD = resetn & (md_busy | accept) & (hiloD | muldivD);

endmodule
